// File: rtl/johnson_pkg.sv
// Shared types and decode helpers for the Johnson phase sequencer.
// Helpers take a zero-extended code plus the live stage count so one body serves any N.
package johnson_pkg;

    localparam int unsigned JC_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN_FREE,
        RUN_BURST,
        RECOVER
    } jc_state_e;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    // Legal Johnson codes have at most one boundary between adjacent stages.
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] q, input int unsigned n);
        logic [JC_MAX_W-1:0] tmp;
        int unsigned         edges;
        tmp   = q;
        edges = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if ((i + 1 < n) && (tmp[0] != tmp[1])) edges++;
            tmp = tmp >> 1;
        end
        return (edges <= 1);
    endfunction

    function automatic int unsigned jc_index(input logic [JC_MAX_W-1:0] q, input int unsigned n);
        logic [JC_MAX_W-1:0] tmp;
        int unsigned         pop;
        tmp = q;
        pop = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (tmp[0]) pop++;
            tmp = tmp >> 1;
        end
        tmp = q >> (n - 1);
        if (q == '0)  return 0;
        else if (tmp[0]) return pop;
        else          return 2 * n - pop;
    endfunction

endpackage

// File: rtl/johnson_phase_sequencer_core.sv
// N-bit Johnson shift register; load takes priority over shift.
module johnson_core #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en_i,
    input  logic         load_en_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset)           q_q <= '0;
        else if (load_en_i)  q_q <= load_val_i;
        else if (shift_en_i) q_q <= {~q_q[0], q_q[N-1:1]};
    end

    assign q_o = q_q;

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Run/burst/pause controller around a Johnson counter with phase decode
// and self-recovery from illegal codes.
module johnson_phase_sequencer
    import johnson_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [CNT_W-1:0]         steps_i,
    input  logic                     hold_i,
    input  logic                     stop_i,
    input  logic                     load_i,
    input  logic [N-1:0]             load_val_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [N-1:0]             jc_q_o,
    output logic [2*N-1:0]           phase_o,
    output logic [$clog2(2*N)-1:0]   phase_idx_o,
    output logic                     err_o
);

    localparam int unsigned IDX_W = $clog2(2 * N);
    localparam int unsigned PH_W  = 2 * N;

    jc_state_e          state_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               was_run_q;

    logic [N-1:0]       jc_q;
    logic [JC_MAX_W-1:0] q_ext;
    logic [JC_MAX_W-1:0] load_ext;
    logic               q_illegal;
    logic               load_legal;
    logic               running;
    logic               last_step;
    logic               shift_en;
    logic               load_en;
    logic [N-1:0]       load_val;
    logic [IDX_W-1:0]   idx;

    assign q_ext      = JC_MAX_W'(jc_q);
    assign load_ext   = JC_MAX_W'(load_val_i);
    assign q_illegal  = !jc_legal(q_ext, N);
    assign load_legal = jc_legal(load_ext, N);
    assign running    = (state_q == RUN_FREE) || (state_q == RUN_BURST);
    assign last_step  = (state_q == RUN_BURST) && (remaining_q == CNT_W'(1));

    // stop_i suppresses the shift except on the final burst edge, where the step still completes.
    always_comb begin
        shift_en = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        if (q_illegal) begin
            load_en = 1'b1;
        end else if (running && !hold_i && (!stop_i || last_step)) begin
            shift_en = 1'b1;
        end else if ((state_q == IDLE) && load_i) begin
            load_en  = 1'b1;
            load_val = load_legal ? load_val_i : '0;
        end
    end

    johnson_core #(
        .N (N)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shift_en),
        .load_en_i  (load_en),
        .load_val_i (load_val),
        .q_o        (jc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            was_run_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (q_illegal) begin
                state_q   <= RECOVER;
                busy_q    <= 1'b0;
                err_q     <= 1'b1;
                was_run_q <= running || ((state_q == RECOVER) && was_run_q);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load_i) begin
                            if (!load_legal) err_q <= 1'b1;
                        end else if (start_i) begin
                            err_q <= 1'b0;
                            if (mode_i == MODE_BURST) begin
                                if (steps_i == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q     <= RUN_BURST;
                                    busy_q      <= 1'b1;
                                    remaining_q <= steps_i;
                                end
                            end else begin
                                state_q <= RUN_FREE;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    RUN_FREE: begin
                        if (stop_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    RUN_BURST: begin
                        if (shift_en) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (last_step) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else if (stop_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    RECOVER: begin
                        state_q   <= IDLE;
                        done_q    <= was_run_q;
                        was_run_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign idx         = IDX_W'(jc_index(q_ext, N));
    assign jc_q_o      = jc_q;
    assign phase_idx_o = idx;
    assign phase_o     = PH_W'(1) << idx;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs,
// a monitor pops and compares them just after the clock edge.
module tb_johnson_phase_sequencer;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic       mode_i;
    logic [7:0] steps_i;
    logic       hold_i;
    logic       stop_i;
    logic       load_i;
    logic [3:0] load_val_i;
    logic       busy_o;
    logic       done_o;
    logic [3:0] jc_q_o;
    logic [7:0] phase_o;
    logic [2:0] phase_idx_o;
    logic       err_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];

    johnson_phase_sequencer #(
        .N     (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .steps_i     (steps_i),
        .hold_i      (hold_i),
        .stop_i      (stop_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .jc_q_o      (jc_q_o),
        .phase_o     (phase_o),
        .phase_idx_o (phase_idx_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_idx(input logic [3:0] q);
        case (q)
            4'b0000: return 3'd0;
            4'b1000: return 3'd1;
            4'b1100: return 3'd2;
            4'b1110: return 3'd3;
            4'b1111: return 3'd4;
            4'b0111: return 3'd5;
            4'b0011: return 3'd6;
            4'b0001: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] ph;
        #1;
        if (sb.size() != 0) begin
            e  = sb.pop_front();
            ph = 8'd1 << ref_idx(e.q);
            chk({e.tag, ".q"},     32'(jc_q_o),      32'(e.q));
            chk({e.tag, ".busy"},  32'(busy_o),      32'(e.busy));
            chk({e.tag, ".done"},  32'(done_o),      32'(e.done));
            chk({e.tag, ".err"},   32'(err_o),       32'(e.err));
            chk({e.tag, ".idx"},   32'(phase_idx_o), 32'(ref_idx(e.q)));
            chk({e.tag, ".phase"}, 32'(phase_o),     32'(ph));
        end
    end

    task automatic cyc(input string tag, input logic [3:0] q, input logic b,
                       input logic d, input logic er);
        exp_t e;
        e = '{tag: tag, q: q, busy: b, done: d, err: er};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; mode_i = 1'b0; steps_i = '0;
        hold_i = 1'b0; stop_i = 1'b0; load_i = 1'b0; load_val_i = '0;
        cyc("rst0", 4'b0000, 0, 0, 0);
        cyc("rst1", 4'b0000, 0, 0, 0);
        reset = 1'b0;
        cyc("idle", 4'b0000, 0, 0, 0);

        // burst of 3
        start_i = 1'b1; mode_i = 1'b1; steps_i = 8'd3;
        cyc("b3_start", 4'b0000, 1, 0, 0);
        start_i = 1'b0;
        cyc("b3_s1", 4'b1000, 1, 0, 0);
        cyc("b3_s2", 4'b1100, 1, 0, 0);
        cyc("b3_s3", 4'b1110, 0, 1, 0);
        cyc("b3_post", 4'b1110, 0, 0, 0);

        // free-run full wrap, then stop
        load_i = 1'b1; load_val_i = 4'b0000;
        cyc("ld0", 4'b0000, 0, 0, 0);
        load_i = 1'b0;
        start_i = 1'b1; mode_i = 1'b0;
        cyc("fr_start", 4'b0000, 1, 0, 0);
        start_i = 1'b0;
        cyc("fr1", 4'b1000, 1, 0, 0);
        cyc("fr2", 4'b1100, 1, 0, 0);
        cyc("fr3", 4'b1110, 1, 0, 0);
        cyc("fr4", 4'b1111, 1, 0, 0);
        cyc("fr5", 4'b0111, 1, 0, 0);
        cyc("fr6", 4'b0011, 1, 0, 0);
        cyc("fr7", 4'b0001, 1, 0, 0);
        cyc("fr8", 4'b0000, 1, 0, 0);
        stop_i = 1'b1;
        cyc("fr_stop", 4'b0000, 0, 1, 0);
        stop_i = 1'b0;
        cyc("fr_post", 4'b0000, 0, 0, 0);

        // zero-length burst
        start_i = 1'b1; mode_i = 1'b1; steps_i = 8'd0;
        cyc("b0_start", 4'b0000, 0, 1, 0);
        start_i = 1'b0;
        cyc("b0_post", 4'b0000, 0, 0, 0);

        // burst of 4 with a 2-cycle hold
        start_i = 1'b1; steps_i = 8'd4;
        cyc("h_start", 4'b0000, 1, 0, 0);
        start_i = 1'b0;
        cyc("h_s1", 4'b1000, 1, 0, 0);
        hold_i = 1'b1;
        cyc("h_hold1", 4'b1000, 1, 0, 0);
        cyc("h_hold2", 4'b1000, 1, 0, 0);
        hold_i = 1'b0;
        cyc("h_s2", 4'b1100, 1, 0, 0);
        cyc("h_s3", 4'b1110, 1, 0, 0);
        cyc("h_s4", 4'b1111, 0, 1, 0);
        cyc("h_post", 4'b1111, 0, 0, 0);

        // illegal load, error cleared by next start, then legal load
        load_i = 1'b1; load_val_i = 4'b1010;
        cyc("ld_bad", 4'b0000, 0, 0, 1);
        load_i = 1'b0;
        start_i = 1'b1; steps_i = 8'd1;
        cyc("clr_start", 4'b0000, 1, 0, 0);
        start_i = 1'b0;
        cyc("clr_s1", 4'b1000, 0, 1, 0);
        cyc("clr_post", 4'b1000, 0, 0, 0);
        load_i = 1'b1; load_val_i = 4'b0011;
        cyc("ld_0011", 4'b0011, 0, 0, 0);
        load_i = 1'b0;

        // stop on the final burst edge still shifts, single done pulse
        start_i = 1'b1; steps_i = 8'd2;
        cyc("ls_start", 4'b0011, 1, 0, 0);
        start_i = 1'b0;
        cyc("ls_s1", 4'b0001, 1, 0, 0);
        stop_i = 1'b1;
        cyc("ls_s2", 4'b0000, 0, 1, 0);
        stop_i = 1'b0;
        cyc("ls_post", 4'b0000, 0, 0, 0);

        // start/load while busy ignored, then reset mid-burst at 1100
        start_i = 1'b1; steps_i = 8'd5;
        cyc("r_start", 4'b0000, 1, 0, 0);
        start_i = 1'b0;
        cyc("r_s1", 4'b1000, 1, 0, 0);
        start_i = 1'b1; steps_i = 8'd0; load_i = 1'b1; load_val_i = 4'b0111;
        cyc("r_ign", 4'b1100, 1, 0, 0);
        start_i = 1'b0; load_i = 1'b0;
        reset = 1'b1;
        cyc("r_reset", 4'b0000, 0, 0, 0);
        reset = 1'b0;
        cyc("r_idle", 4'b0000, 0, 0, 0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
